// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM states and lane-select helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  // Pick the addressed byte/half out of a little-endian word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of a memory word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word,
                                              input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    case (f3)
      F3_B: r[{off, 3'b000} +: 8] = wd[7:0];
      F3_H: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [2:0]            REQ_FUNCT3;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  RESP_VALID;
  logic                  RESP_ERR;
  logic [DATA_WIDTH-1:0] RESP_RDATA;
  logic [ADDR_WIDTH-1:0] MEM_A;
  logic [DATA_WIDTH-1:0] MEM_WD;
  logic                  MEM_WE;
  logic [DATA_WIDTH-1:0] MEM_RD;

  // Core datapath plus data memory side.
  modport master (
    output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, MEM_RD,
    input  REQ_READY, RESP_VALID, RESP_ERR, RESP_RDATA, MEM_A, MEM_WD, MEM_WE
  );

  // Load/store unit side.
  modport slave (
    input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, MEM_RD,
    output REQ_READY, RESP_VALID, RESP_ERR, RESP_RDATA, MEM_A, MEM_WD, MEM_WE
  );
endinterface

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - combinational load extension and store lane merge
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  // Both results are pure lane selects on the current memory word.
  always_comb begin
    load_data  = load_extend(funct3, offset, mem_word);
    store_word = store_merge(funct3, offset, mem_word, store_data);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32I load/store initiator for Data_memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_MEM_LENGTH = 64
) (
  input logic              CLK,
  input logic              RST,
  load_store_unit_if.slave bus
);

  localparam logic [ADDR_WIDTH-3:0] MEM_WORDS = (ADDR_WIDTH-2)'(DATA_MEM_LENGTH);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [2:0]            f3_q;
  logic                  err_q;
  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  assign bus.REQ_READY = (state == IDLE) && !RST;
  assign accept        = bus.REQ_VALID && bus.REQ_READY;
  assign word_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  lsu_data_align u_align (
    .funct3     (f3_q),
    .offset     (addr_q[1:0]),
    .mem_word   (bus.MEM_RD),
    .store_data (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Reject illegal encodings, misalignment and out-of-range words before touching memory.
  always_comb begin
    req_err = 1'b0;
    if (bus.REQ_FUNCT3 == 3'b011 || bus.REQ_FUNCT3 == 3'b110 || bus.REQ_FUNCT3 == 3'b111)
      req_err = 1'b1;
    if (bus.REQ_WE && bus.REQ_FUNCT3[2])
      req_err = 1'b1;
    if (bus.REQ_FUNCT3[1:0] == 2'b01 && bus.REQ_ADDR[0])
      req_err = 1'b1;
    if (bus.REQ_FUNCT3 == F3_W && bus.REQ_ADDR[1:0] != 2'b00)
      req_err = 1'b1;
    if (bus.REQ_ADDR[ADDR_WIDTH-1:2] >= MEM_WORDS)
      req_err = 1'b1;
  end

  // State register; reset aborts whatever access is in flight.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and memory/response outputs decoded from the current state.
  always_comb begin
    state_n        = state;
    bus.MEM_A      = '0;
    bus.MEM_WD     = '0;
    bus.MEM_WE     = 1'b0;
    bus.RESP_VALID = 1'b0;
    bus.RESP_ERR   = 1'b0;
    bus.RESP_RDATA = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                    state_n = RESP;
          else if (!bus.REQ_WE)           state_n = LOAD;
          else if (bus.REQ_FUNCT3 == F3_W) state_n = WRITE;
          else                            state_n = RMW_RD;
        end
      end
      LOAD: begin
        bus.MEM_A = word_addr;
        state_n   = RESP;
      end
      RMW_RD: begin
        bus.MEM_A = word_addr;
        state_n   = WRITE;
      end
      WRITE: begin
        bus.MEM_A  = word_addr;
        bus.MEM_WD = merge_q;
        // A reset landing on the write cycle must not commit the store.
        bus.MEM_WE = !RST;
        state_n    = RESP;
      end
      RESP: begin
        bus.RESP_VALID = 1'b1;
        bus.RESP_ERR   = err_q;
        bus.RESP_RDATA = rdata_q;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture, load result and read-modify-write merge registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.REQ_ADDR;
        wdata_q <= bus.REQ_WDATA;
        f3_q    <= bus.REQ_FUNCT3;
        err_q   <= req_err;
        rdata_q <= '0;
        // Full-word stores skip the read, so the write word is the store data itself.
        merge_q <= bus.REQ_WDATA;
      end
      if (state == LOAD)   rdata_q <= load_data;
      if (state == RMW_RD) merge_q <= store_word;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory interface. It accepts one load/store request at a time from the core datapath, runs the word-granular accesses against Data_memory, and returns one response pulse. It implements RV32I byte, halfword and word loads and stores, with sign and zero extension. Sub-word stores are done as read-modify-write, because the memory has only a single whole-word WE. It sits between the core's execute stage and Data_memory in place of the direct A/WD/WE wiring.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, byte-address width.
DATA_MEM_LENGTH, 64, number of words in Data_memory; used for the range check.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
REQ_VALID  input  1  request strobe.
REQ_READY  output  1  unit can accept a request this cycle.
REQ_WE  input  1  1 = store, 0 = load.
REQ_FUNCT3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ_ADDR  input  ADDR_WIDTH  byte address.
REQ_WDATA  input  DATA_WIDTH  store data, right-aligned.
RESP_VALID  output  1  one-cycle completion pulse.
RESP_ERR  output  1  request rejected; valid only with RESP_VALID.
RESP_RDATA  output  DATA_WIDTH  extended load data; valid with RESP_VALID on loads, 0 otherwise.
MEM_A  output  ADDR_WIDTH  word-aligned byte address to Data_memory (bits [1:0] = 0).
MEM_WD  output  DATA_WIDTH  write data to Data_memory.
MEM_WE  output  1  write enable to Data_memory.
MEM_RD  input  DATA_WIDTH  Data_memory read data; combinational from MEM_A in the same cycle.

Behaviour:
- Clocking and reset:
  - Single clock CLK.
  - RST is synchronous and active-high.
  - On reset: state = IDLE, RESP_VALID=0, RESP_ERR=0, RESP_RDATA=0, MEM_WE=0, MEM_A=0, MEM_WD=0.
- REQ_READY = (state==IDLE) && !RST. A request is accepted on a rising edge with REQ_VALID && REQ_READY, which latches addr, wdata, funct3 and we.
- Error checks at accept time. Any one of the following sets RESP_ERR:
  - funct3 is 011, 110 or 111;
  - store with funct3[2]=1;
  - H/HU access with addr[0]=1;
  - W access with addr[1:0]!=0;
  - addr[ADDR_WIDTH-1:2] >= DATA_MEM_LENGTH.
  Error path goes to RESP. No memory access occurs and MEM_WE stays 0.
- States:
  - IDLE -> LOAD on a load.
  - IDLE -> WRITE on SW.
  - IDLE -> RMW_RD on SB/SH.
  - IDLE -> RESP on error.
  - LOAD: MEM_A=word addr. Select the byte or half by addr[1:0] (little-endian). Sign-extend for B/H, zero-extend for BU/HU, pass-through for W. Register the result into RESP_RDATA. Go to RESP.
  - RMW_RD: MEM_A=word addr. Merge register = MEM_RD with the target lane replaced by wdata[7:0] (B) or wdata[15:0] (H). Go to WRITE.
  - WRITE: MEM_A=word addr, MEM_WD=merged word (full wdata for SW), MEM_WE=1 for exactly this cycle. Go to RESP.
  - RESP: RESP_VALID=1 for one cycle; RESP_ERR as determined. Go to IDLE.
- Outputs outside states:
  - MEM_WE=0 outside WRITE.
  - MEM_A and MEM_WD are 0 in IDLE and RESP.
- Latency from the accept edge N:
  - error: RESP_VALID at N+1.
  - load / SW: RESP_VALID at N+2.
  - SB/SH: RESP_VALID at N+3.
- No back-pressure on the response. The next request can be accepted in the cycle after RESP, so throughput is at most one request every 3 or 4 cycles.
- REQ_VALID while busy is ignored (REQ_READY=0). The requester holds the request until it is accepted.
- Reset mid-operation:
  - RST asserted in any state returns to IDLE on that edge.
  - MEM_WE is gated by !RST, so a store whose WRITE cycle coincides with RST is not committed.
  - No RESP_VALID is produced for the aborted request.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding (IDLE, LOAD, RMW_RD, WRITE, RESP);
  - the lane-select helpers.
- One combinational sub-module, lsu_data_align:
  - inputs: funct3, addr[1:0], mem word, store data;
  - outputs: extended load data and merged store word.
- The FSM and the error check stay in load_store_unit.

Test Plan:
1. SW addr=4 wdata=22 -> MEM_WE=1 at N+1 with MEM_A=4, MEM_WD=22. RESP_VALID at N+2, ERR=0. A following LW addr=4 returns RESP_RDATA=22.
2. Mem[8]=0x11223344. SB addr=9 wdata=0xAB -> MEM_WE only at N+2, MEM_WD=0x1122AB44, RESP_VALID at N+3.
3. Mem[12]=0x80FF7F81. LB addr=12 -> 0xFFFFFF81. LBU addr=13 -> 0x0000007F. LH addr=14 -> 0xFFFF80FF. LHU addr=14 -> 0x000080FF.
4. Error requests, each returning RESP_VALID at N+1 with ERR=1 and MEM_WE never high:
   - LW addr=6 (misaligned);
   - SH addr=3 (misaligned);
   - LW addr=256 (out of range at length 64);
   - store with funct3=100.
5. Raise RST during the WRITE cycle of SW addr=0 wdata=0x5A -> MEM_WE=0. A subsequent LW addr=0 returns the old value, with no RESP for the aborted store.
6. Hold REQ_VALID during a busy SB -> REQ_READY=0 until the cycle after RESP. Exactly one access sequence per accepted request.
